psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_acc_pkg.sv | 24 ++
 rtl/conv_index_map.sv | 37 +++
 rtl/psum_accumulator.sv | 149 ++++++++++++++
 tb/tb_psum_accumulator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_pkg.sv
// Shared constants and types for the partial-sum accumulator.
//   - default widths/counts for the top-level parameters
//   - convolution geometry: 3x3 kernel over a 6x6 input gives a 4x4 output
//   - accumulator state enum
package psum_acc_pkg;

    localparam int PSUM_BW_DEF = 16;
    localparam int COL_DEF     = 8;
    localparam int KIJ_NUM_DEF = 9;
    localparam int NIJ_NUM_DEF = 36;

    localparam int K_DIM   = 3;
    localparam int IN_DIM  = 6;
    localparam int OUT_DIM = 4;
    localparam int OUT_NUM = OUT_DIM * OUT_DIM;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DONE
    } acc_state_t;

endpackage

// File: rtl/conv_index_map.sv
// Maps a (kernel index, input index) tag pair to the output position it
// contributes to. Purely combinational.
// Ports:
//   kij       in  4  kernel position, ki = kij / 3, kj = kij % 3
//   nij       in  6  input position,  r  = nij / 6, c  = nij % 6
//   o_nij     out 4  output index o_r*4 + o_c (only meaningful when in_window)
//   in_window out 1  tag is legal and lands inside the 4x4 output
//   tag_err   out 1  kij > 8 or nij > 35
module conv_index_map
    import psum_acc_pkg::*;
(
    input  logic [3:0] kij,
    input  logic [5:0] nij,
    output logic [3:0] o_nij,
    output logic       in_window,
    output logic       tag_err
);

    int ki, kj, r, c, o_r, o_c;

    always_comb begin
        ki  = int'(kij) / K_DIM;
        kj  = int'(kij) % K_DIM;
        r   = int'(nij) / IN_DIM;
        c   = int'(nij) % IN_DIM;
        o_r = r - ki;
        o_c = c - kj;

        tag_err   = (int'(kij) >= K_DIM * K_DIM) || (int'(nij) >= IN_DIM * IN_DIM);
        in_window = !tag_err &&
                    (o_r >= 0) && (o_r < OUT_DIM) &&
                    (o_c >= 0) && (o_c < OUT_DIM);
        // Out-of-window values are truncated garbage; the write is gated by in_window.
        o_nij     = 4'(o_r * OUT_DIM + o_c);
    end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: folds KIJ_NUM*NIJ_NUM tagged psum rows into a
// 4x4 grid of output rows (COL signed columns each).
// Optional build macro: PSUM_ACC_RELU_EN clamps negative read columns to 0
// (stored sums are unaffected).
// Ports:
//   s_axi_aclk    in   clock, rising edge
//   s_axi_aresetn in   asynchronous active-low reset
//   start         in   pulse: clear accumulator and begin a pass (IDLE/DONE only)
//   in_valid      in   psum row offered
//   in_ready      out  row accepted this cycle (ACCUM only)
//   in_data       in   COL x PSUM_BW signed psum row
//   in_kij/in_nij in   row tags
//   busy          out  CLEAR or ACCUM
//   done          out  pass complete
//   err           out  sticky bad-tag flag
//   row_count     out  rows accepted this pass
//   rd_addr       in   output index to read
//   rd_data       out  registered accumulated row, 1-cycle latency
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int PSUM_BW = PSUM_BW_DEF,
    parameter int COL     = COL_DEF,
    parameter int KIJ_NUM = KIJ_NUM_DEF,
    parameter int NIJ_NUM = NIJ_NUM_DEF
)
(
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COL*PSUM_BW-1:0] in_data,
    input  logic [3:0]             in_kij,
    input  logic [5:0]             in_nij,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [8:0]             row_count,
    input  logic [3:0]             rd_addr,
    output logic [COL*PSUM_BW-1:0] rd_data
);

    localparam int         ROW_W    = COL * PSUM_BW;
    localparam logic [8:0] LAST_ROW = 9'(KIJ_NUM * NIJ_NUM - 1);
    localparam logic [3:0] LAST_CLR = 4'(OUT_NUM - 1);

    acc_state_t       state_reg, state_next;
    logic [3:0]       clr_cnt_reg;
    logic [8:0]       row_count_reg;
    logic             err_reg;
    logic [ROW_W-1:0] rd_data_reg;
    logic [ROW_W-1:0] acc_mem [OUT_NUM];

    logic             xfer;
    logic             enter_clear;
    logic [3:0]       map_o_nij;
    logic             map_in_window;
    logic             map_tag_err;
    logic [ROW_W-1:0] sum_row;
    logic [ROW_W-1:0] rd_row;
    logic [ROW_W-1:0] rd_view;

    conv_index_map u_map (
        .kij       (in_kij),
        .nij       (in_nij),
        .o_nij     (map_o_nij),
        .in_window (map_in_window),
        .tag_err   (map_tag_err)
    );

    assign in_ready    = (state_reg == ST_ACCUM);
    assign busy        = (state_reg == ST_CLEAR) || (state_reg == ST_ACCUM);
    assign done        = (state_reg == ST_DONE);
    assign err         = err_reg;
    assign row_count   = row_count_reg;
    assign rd_data     = rd_data_reg;
    assign xfer        = in_valid && in_ready;
    assign enter_clear = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign rd_row      = acc_mem[rd_addr];

    // Per-column wrap-around add and read view. The accumulator is a flop
    // array, so the add reads the current value and writes it back on the
    // same edge: consecutive rows to the same entry need no forwarding.
    genvar gi;
    generate
        for (gi = 0; gi < COL; gi++) begin : g_col
            assign sum_row[gi*PSUM_BW +: PSUM_BW] =
                acc_mem[map_o_nij][gi*PSUM_BW +: PSUM_BW] + in_data[gi*PSUM_BW +: PSUM_BW];
`ifdef PSUM_ACC_RELU_EN
            assign rd_view[gi*PSUM_BW +: PSUM_BW] =
                rd_row[gi*PSUM_BW + PSUM_BW - 1] ? '0 : rd_row[gi*PSUM_BW +: PSUM_BW];
`else
            assign rd_view[gi*PSUM_BW +: PSUM_BW] = rd_row[gi*PSUM_BW +: PSUM_BW];
`endif
        end
    endgenerate

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start) state_next = ST_CLEAR;
            ST_CLEAR:         if (clr_cnt_reg == LAST_CLR) state_next = ST_ACCUM;
            ST_ACCUM:         if (xfer && (row_count_reg == LAST_ROW)) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < OUT_NUM; i++) begin
                acc_mem[i] <= '0;
            end
            clr_cnt_reg   <= '0;
            row_count_reg <= '0;
            err_reg       <= 1'b0;
            rd_data_reg   <= '0;
        end else begin
            if (enter_clear) begin
                clr_cnt_reg   <= '0;
                row_count_reg <= '0;
                err_reg       <= 1'b0;
            end
            if (state_reg == ST_CLEAR) begin
                acc_mem[clr_cnt_reg] <= '0;
                clr_cnt_reg          <= clr_cnt_reg + 4'd1;
            end
            if (xfer) begin
                row_count_reg <= row_count_reg + 9'd1;
                if (map_tag_err) begin
                    err_reg <= 1'b1;
                end
                if (map_in_window) begin
                    acc_mem[map_o_nij] <= sum_row;
                end
            end
            rd_data_reg <= rd_view;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    localparam int PBW = 16;
    localparam int NC  = 8;
    localparam int W   = PBW * NC;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [3:0]   in_kij;
    logic [5:0]   in_nij;
    logic         busy;
    logic         done;
    logic         err;
    logic [8:0]   row_count;
    logic [3:0]   rd_addr;
    logic [W-1:0] rd_data;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [W-1:0] m_acc [16];
    int           m_rows;
    logic         m_err;

    // Read scoreboard
    logic [W-1:0] exp_q [$];
    string        tag_q [$];

    always #5 clk = ~clk;

    psum_accumulator dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_kij        (in_kij),
        .in_nij        (in_nij),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .row_count     (row_count),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] view(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
`ifdef PSUM_ACC_RELU_EN
        for (int j = 0; j < NC; j++) begin
            if (v[j*PBW + PBW - 1]) r[j*PBW +: PBW] = '0;
        end
`endif
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_acc[i] = '0;
        m_rows = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_apply(input logic [3:0] k, input logic [5:0] n, input logic [W-1:0] d);
        int orow, ocol, idx;
        m_rows++;
        if (k > 4'd8 || n > 6'd35) begin
            m_err = 1'b1;
            return;
        end
        orow = int'(n) / 6 - int'(k) / 3;
        ocol = int'(n) % 6 - int'(k) % 3;
        if (orow >= 0 && orow <= 3 && ocol >= 0 && ocol <= 3) begin
            idx = orow * 4 + ocol;
            for (int j = 0; j < NC; j++) begin
                m_acc[idx][j*PBW +: PBW] = m_acc[idx][j*PBW +: PBW] + d[j*PBW +: PBW];
            end
        end
    endtask

    // Called at a negedge; leaves in_valid asserted so rows can stream.
    task automatic send_row(input logic [3:0] k, input logic [5:0] n, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_kij   = k;
        in_nij   = n;
        in_data  = d;
        if (in_ready) model_apply(k, n, d);
        @(negedge clk);
    endtask

    task automatic read_chk(input logic [3:0] a, input string tag);
        in_valid = 1'b0;
        rd_addr  = a;
        exp_q.push_back(view(m_acc[a]));
        tag_q.push_back($sformatf("%s[%0d]", tag, a));
        @(negedge clk);
        chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 16; a++) read_chk(4'(a), tag);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_row_count"}, W'(row_count), W'(m_rows));
        chk({tag, "_err"}, W'(err), W'(m_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready", W'(in_ready), W'(1));
        model_clear();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_kij   = '0;
        in_nij   = '0;
        rd_addr  = '0;
        model_clear();

        // Reset state, then 20 idle cycles
        repeat (2) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_rd_data", rd_data, W'(0));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_in_ready", W'(in_ready), W'(0));
        chk("idle_busy", W'(busy), W'(0));
        chk("idle_done", W'(done), W'(0));
        chk("idle_err", W'(err), W'(0));
        chk("idle_row_count", W'(row_count), W'(0));
        chk("idle_rd_data", rd_data, W'(0));

        // Start: exactly 16 clear cycles before in_ready
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clear_busy", W'(busy), W'(1));
        chk("clear_ready0", W'(in_ready), W'(0));
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("clear_ready_c%0d", i), W'(in_ready), W'(0));
        end
        @(negedge clk);
        chk("clear_ready_c16", W'(in_ready), W'(1));
        model_clear();

        // In-window and out-of-window rows
        send_row(4'd4, 6'd7, W'(16'h0005));
        in_valid = 1'b0;
        read_chk(4'd0, "win_acc0");
        send_row(4'd4, 6'd0, W'(16'h0005));
        in_valid = 1'b0;
        check_status("oow");
        read_all("oow_acc");

        // Start mid-ACCUM is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midstart_in_ready", W'(in_ready), W'(1));
        chk("midstart_busy", W'(busy), W'(1));
        check_status("midstart");

        // Reset mid-ACCUM returns to IDLE with everything cleared
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", W'(in_ready), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_row_count", W'(row_count), W'(0));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle_busy", W'(busy), W'(0));
        read_all("midrst_acc");

        // Negative sum read-out
        do_start();
        send_row(4'd0, 6'd0, W'(16'hFFFE));
        in_valid = 1'b0;
        read_chk(4'd0, "neg_acc0");

        // Wrap on overflow, then bad tags
        do_reset();
        do_start();
        send_row(4'd0, 6'd0, W'(16'h7FFF));
        send_row(4'd0, 6'd0, W'(16'h0001));
        in_valid = 1'b0;
        read_chk(4'd0, "wrap_acc0");
        send_row(4'd9, 6'd0, W'(16'h1234));
        in_valid = 1'b0;
        check_status("badkij");
        read_chk(4'd0, "badkij_acc0");
        send_row(4'd1, 6'd36, W'(16'h0077));
        in_valid = 1'b0;
        check_status("badnij");
        read_all("badnij_acc");

        // Full pass, every column 1, rows back-to-back
        do_reset();
        do_start();
        for (int k = 0; k < 9; k++) begin
            for (int n = 0; n < 36; n++) begin
                chk($sformatf("stream_ready_k%0d_n%0d", k, n), W'(in_ready), W'(1));
                send_row(4'(k), 6'(n), {NC{16'h0001}});
            end
        end
        in_valid = 1'b0;
        chk("full_done", W'(done), W'(1));
        chk("full_in_ready", W'(in_ready), W'(0));
        chk("full_busy", W'(busy), W'(0));
        check_status("full");
        read_all("full_acc");
        chk("full_acc15_const", rd_data, {NC{16'h0009}});

        // Start from DONE begins a new pass
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", W'(busy), W'(1));
        chk("restart_done", W'(done), W'(0));
        chk("restart_row_count", W'(row_count), W'(0));

        if (exp_q.size() != 0) chk("sb_leftover", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
